// File: rtl/axi_slave.sv
// axi_slave: AXI3-style memory slave with independent write and read FSMs.
//
// Storage is MEM_DEPTH 32-bit words, indexed by addr[31:2]. One transaction
// at a time per direction; AWREADY/ARREADY are only high while idle.
//
// Ports
//   ACLK, ARESET             clock, synchronous active-high reset
//   AW*  (in) / AWREADY      write address channel
//   W*   (in) / WREADY       write data channel (WID not checked)
//   B*   (out) / BREADY      write response channel (BRESP is 4 bits wide)
//   AR*  (in) / ARREADY      read address channel (ARADDR[32] ignored)
//   R*   (out) / RREADY      read data channel
//
// Parameters
//   MEM_DEPTH  words of storage, power of two, 4..1024
//   ERR_RESP   response code for error beats (OKAY is 0)
//
// Optional feature macro: AXI_SLAVE_WSTRB_EN
//   defined   : only byte lanes with WSTRB[i]=1 are written
//   undefined : WSTRB ignored, full word written on every good beat
module axi_slave #(
  parameter int unsigned MEM_DEPTH = 64,
  parameter int unsigned ERR_RESP  = 2
) (
  input  logic        ACLK,
  input  logic        ARESET,
  // AW channel
  input  logic [3:0]  AWID,
  input  logic [31:0] AWADDR,
  input  logic [3:0]  AWLEN,
  input  logic [2:0]  AWSIZE,
  input  logic [1:0]  AWBURST,
  input  logic        AWVALID,
  output logic        AWREADY,
  // W channel
  input  logic [3:0]  WID,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
  input  logic        WLAST,
  input  logic        WVALID,
  output logic        WREADY,
  // B channel
  output logic [3:0]  BID,
  output logic [3:0]  BRESP,
  output logic        BVALID,
  input  logic        BREADY,
  // AR channel
  input  logic [3:0]  ARID,
  input  logic [32:0] ARADDR,
  input  logic [3:0]  ARLEN,
  input  logic [2:0]  ARSIZE,
  input  logic [1:0]  ARBURST,
  input  logic        ARVALID,
  output logic        ARREADY,
  // R channel
  output logic [3:0]  RID,
  output logic [31:0] RDATA,
  output logic [1:0]  RRESP,
  output logic        RLAST,
  output logic        RVALID,
  input  logic        RREADY
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);
  localparam logic [3:0]  ErrB = 4'(ERR_RESP);
  localparam logic [1:0]  ErrR = 2'(ERR_RESP);

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

  logic [31:0] mem [MEM_DEPTH];

  // Index of the final beat (beat counter value) for a given burst type.
  function automatic logic [3:0] last_beat(input logic [3:0] len, input logic [1:0] burst);
    unique case (burst)
      2'b00:   last_beat = 4'd0;
      2'b01:   last_beat = len;
      default: last_beat = 4'd3;
    endcase
  endfunction

  // WRAP4 keeps idx[29:2] fixed; everything else steps linearly.
  function automatic logic [29:0] next_idx(input logic [29:0] idx, input logic [1:0] burst);
    if (burst == 2'b10) next_idx = {idx[29:2], idx[1:0] + 2'd1};
    else                next_idx = idx + 30'd1;
  endfunction

  function automatic logic out_of_range(input logic [29:0] idx);
    out_of_range = {2'b00, idx} >= MEM_DEPTH;
  endfunction

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_e    w_state_q;
  logic [3:0]  w_id_q;
  logic [29:0] w_idx_q;
  logic [1:0]  w_burst_q;
  logic [3:0]  w_last_q;
  logic [3:0]  w_cnt_q;
  logic        w_size_err_q;
  logic        w_err_q;

  logic w_beat_err;
  logic w_final;
  logic w_last_bad;
  logic w_beat;
  logic mem_we;

  always_comb begin
    w_beat     = (w_state_q == WData) && WVALID;
    w_beat_err = w_size_err_q || out_of_range(w_idx_q);
    w_final    = (w_cnt_q == w_last_q);
    w_last_bad = (WLAST != w_final);
    // Once a burst has gone wrong, no later beat of it touches memory.
    mem_we     = w_beat && !ARESET && !w_beat_err && !w_last_bad && !w_err_q;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q    <= WIdle;
      AWREADY      <= 1'b1;
      WREADY       <= 1'b0;
      BVALID       <= 1'b0;
      BRESP        <= 4'd0;
      BID          <= 4'd0;
      w_id_q       <= 4'd0;
      w_idx_q      <= 30'd0;
      w_burst_q    <= 2'b00;
      w_last_q     <= 4'd0;
      w_cnt_q      <= 4'd0;
      w_size_err_q <= 1'b0;
      w_err_q      <= 1'b0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          if (AWVALID) begin
            w_id_q       <= AWID;
            w_idx_q      <= AWADDR[31:2];
            w_burst_q    <= AWBURST;
            w_last_q     <= last_beat(AWLEN, AWBURST);
            w_cnt_q      <= 4'd0;
            w_size_err_q <= (AWSIZE != 3'b010);
            w_err_q      <= 1'b0;
            AWREADY      <= 1'b0;
            WREADY       <= 1'b1;
            w_state_q    <= WData;
          end
        end
        WData: begin
          if (WVALID) begin
            w_idx_q <= next_idx(w_idx_q, w_burst_q);
            w_cnt_q <= w_cnt_q + 4'd1;
            if (w_beat_err || w_last_bad) w_err_q <= 1'b1;
            if (w_final) begin
              WREADY    <= 1'b0;
              BVALID    <= 1'b1;
              BID       <= w_id_q;
              BRESP     <= (w_err_q || w_beat_err || w_last_bad) ? ErrB : 4'd0;
              w_state_q <= WResp;
            end
          end
        end
        WResp: begin
          if (BREADY) begin
            BVALID    <= 1'b0;
            AWREADY   <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Memory is deliberately not reset.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
`ifdef AXI_SLAVE_WSTRB_EN
      for (int i = 0; i < 4; i++) begin
        if (WSTRB[i]) mem[w_idx_q[AW-1:0]][8*i +: 8] <= WDATA[8*i +: 8];
      end
`else
      mem[w_idx_q[AW-1:0]] <= WDATA;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_e    r_state_q;
  logic [29:0] r_idx_q;
  logic [1:0]  r_burst_q;
  logic [3:0]  r_last_q;
  logic [3:0]  r_cnt_q;
  logic        r_size_err_q;

  logic [29:0] rd_idx;
  logic        rd_err;
  logic [31:0] rd_word;

  // Word to present next: the burst's first beat while idle, else the one after the current.
  always_comb begin
    if (r_state_q == RIdle) begin
      rd_idx = ARADDR[31:2];
      rd_err = (ARSIZE != 3'b010) || out_of_range(ARADDR[31:2]);
    end else begin
      rd_idx = next_idx(r_idx_q, r_burst_q);
      rd_err = r_size_err_q || out_of_range(next_idx(r_idx_q, r_burst_q));
    end
    rd_word = rd_err ? 32'd0 : mem[rd_idx[AW-1:0]];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state_q    <= RIdle;
      ARREADY      <= 1'b1;
      RVALID       <= 1'b0;
      RLAST        <= 1'b0;
      RRESP        <= 2'd0;
      RID          <= 4'd0;
      RDATA        <= 32'd0;
      r_idx_q      <= 30'd0;
      r_burst_q    <= 2'b00;
      r_last_q     <= 4'd0;
      r_cnt_q      <= 4'd0;
      r_size_err_q <= 1'b0;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          if (ARVALID) begin
            r_idx_q      <= ARADDR[31:2];
            r_burst_q    <= ARBURST;
            r_last_q     <= last_beat(ARLEN, ARBURST);
            r_cnt_q      <= 4'd0;
            r_size_err_q <= (ARSIZE != 3'b010);
            RID          <= ARID;
            RVALID       <= 1'b1;
            RLAST        <= (last_beat(ARLEN, ARBURST) == 4'd0);
            RDATA        <= rd_word;
            RRESP        <= rd_err ? ErrR : 2'd0;
            ARREADY      <= 1'b0;
            r_state_q    <= RData;
          end
        end
        RData: begin
          if (RREADY) begin
            if (RLAST) begin
              RVALID    <= 1'b0;
              RLAST     <= 1'b0;
              ARREADY   <= 1'b1;
              r_state_q <= RIdle;
            end else begin
              r_idx_q <= rd_idx;
              r_cnt_q <= r_cnt_q + 4'd1;
              RLAST   <= ((r_cnt_q + 4'd1) == r_last_q);
              RDATA   <= rd_word;
              RRESP   <= rd_err ? ErrR : 2'd0;
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

`ifdef AXI_SLAVE_WSTRB_EN
  logic unused_bits;
  assign unused_bits = ^{ARADDR[32], ARADDR[1:0], AWADDR[1:0], WID};
`else
  logic unused_bits;
  assign unused_bits = ^{ARADDR[32], ARADDR[1:0], AWADDR[1:0], WID, WSTRB};
`endif

endmodule

// File: doc/axi_slave.md
AXI_SLAVE -- requirements
Module: axi_slave

Interface
REQ-001 Parameter MEM_DEPTH, 64, number of 32-bit words in internal storage; power of two, 4..1024.
REQ-002 Parameter ERR_RESP, 2, BRESP/RRESP code for error beats (SLVERR); OKAY is 0.
REQ-003 ACLK  input  1  single clock, all logic on rising edge.
REQ-004 ARESET  input  1  reset, synchronous, active-high.
REQ-005 AW channel: AWID in 4, AWADDR in 32, AWLEN in 4, AWSIZE in 3, AWBURST in 2, AWVALID in 1, AWREADY out 1.
REQ-006 W channel: WID in 4, WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, WREADY out 1.
REQ-007 B channel: BID out 4, BRESP out 4, BVALID out 1, BREADY in 1.
REQ-008 AR channel: ARID in 4, ARADDR in 33 (bit 32 ignored), ARLEN in 4, ARSIZE in 3, ARBURST in 2, ARVALID in 1, ARREADY out 1.
REQ-009 R channel: RID out 4, RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, RREADY in 1.

Function
REQ-010 Burst encoding: 00 SINGLE (1 beat, AxLEN ignored), 01 INCR (AxLEN+1 beats), 10 WRAP4 (4 beats, wrap at 16-byte boundary), 11 INCR4 (4 beats).
REQ-011 Word index = addr[31:2]; INCR/INCR4 add 4 per beat; WRAP4 increments addr[3:2] modulo 4, addr[31:4] fixed.
REQ-012 Beat is in error if AxSIZE != 3'b010 or word index >= MEM_DEPTH; error beats do not write, read data 0.
REQ-013 Write FSM W_IDLE/W_DATA/W_RESP; AWREADY=1 only in W_IDLE; AW handshake captures AWID/addr/len/burst, -> W_DATA.
REQ-014 W_DATA: WREADY=1; each WVALID&WREADY beat commits at that edge and advances address and beat counter.
REQ-015 Final beat = counter reaching burst length; WLAST on any other beat, or missing on final beat, marks burst error; -> W_RESP after final beat.
REQ-016 W_RESP: BVALID=1 first cycle after last W handshake, BID=captured AWID, BRESP=ERR_RESP if any beat errored else 0; held stable until BREADY; BVALID&BREADY -> W_IDLE.
REQ-017 WID not checked; WID != AWID does not alter behaviour.
REQ-018 Read FSM R_IDLE/R_DATA; ARREADY=1 only in R_IDLE; AR handshake at cycle N gives RVALID=1 with first beat at N+1.
REQ-019 R_DATA: RDATA/RRESP/RLAST/RID registered, held stable while RVALID&!RREADY; on RVALID&RREADY next beat presented next cycle, no bubble.
REQ-020 RLAST=1 only on final beat; RRESP per beat (ERR_RESP or 0); final handshake -> R_IDLE, RVALID=0 next cycle.
REQ-021 Read and write FSMs independent; same-cycle write and read of one word: read returns pre-write data.
REQ-022 AR handshake never accepted while R_DATA; AW never while W_DATA/W_RESP (no outstanding transactions).

Reset
REQ-023 ARESET high at a rising edge: both FSMs to IDLE, AWREADY=1, ARREADY=1, WREADY=0, BVALID=0, RVALID=0, RLAST=0, BRESP=0, RRESP=0, BID=0, RID=0, RDATA=0.
REQ-024 Reset mid-burst aborts the burst without response; memory contents not cleared.

Configuration
REQ-025 Macro AXI_SLAVE_WSTRB_EN defined: only bytes with WSTRB[i]=1 written; WSTRB=0 is a legal no-write beat.
REQ-026 Macro undefined: WSTRB ignored, full 32-bit word written every non-error beat.

Verification
REQ-027 Reset, AW addr 0x10 INCR4 id 3, data 1..4 WLAST on 4th -> BID=3 BRESP=0; AR same -> RDATA 1,2,3,4, RLAST on 4th, RRESP=0.
REQ-028 WRAP4 write at 0x28 data A,B,C,D -> reads 0x20..0x2C return C,D,A,B.
REQ-029 Read burst INCR len 3 with RREADY low 3 cycles on beat 2 -> RDATA/RLAST stable, no beat lost or repeated.
REQ-030 Write 0x1000 (MEM_DEPTH=64), AWSIZE=3'b001, or early WLAST -> BRESP=2, memory unchanged.
REQ-031 With AXI_SLAVE_WSTRB_EN: word 0xFFFFFFFF, write 0x12345678 WSTRB=0101 -> read 0xFF34FF78; without macro -> 0x12345678.
REQ-032 ARESET asserted mid write burst beat 2 -> next cycle AWREADY=1, BVALID=0, earlier-committed beats retained.
